// File: rtl/dvp_video_tx.sv
// dvp_video_tx: OV5640-style DVP transmitter.
// Sends RGB565 pixels as high byte then low byte on cam_data, framed by
// cam_vsync (frame sync) and cam_href (line valid). sys_clk doubles as pclk.
// Pixels come either from an external FIFO (pix_req/pix_data) or from an
// internal 8-bar colour pattern, chosen per frame by use_pattern.
//
// Ports:
//   sys_clk      in   clock, also the DVP pixel clock
//   sys_rst      in   asynchronous active-high reset
//   enable       in   start/continue frames
//   use_pattern  in   1 = colour bars, 0 = external pix_data (latched at frame start)
//   pix_req      out  one-cycle read strobe to the external pixel FIFO
//   pix_data     in   RGB565 pixel, valid one cycle after pix_req
//   cam_vsync    out  frame sync, active high
//   cam_href     out  line valid, active high
//   cam_data     out  byte data
//   frame_done   out  one-cycle pulse on the last clock of a frame
module dvp_video_tx #(
  parameter int unsigned H_PIXEL  = 640,
  parameter int unsigned V_PIXEL  = 480,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned VS_LINES = 4,
  parameter int unsigned V_BACK   = 16,
  parameter int unsigned V_FRONT  = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic        use_pattern,
  output logic        pix_req,
  input  logic [15:0] pix_data,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done
);

  localparam int unsigned HW       = 12;
  localparam int unsigned VW       = 11;
  localparam int unsigned ACT_CLKS = 2 * H_PIXEL;
  localparam int unsigned LINE_LEN = ACT_CLKS + H_BLANK;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            pattern;
  logic [15:0]     pix_hold;

  logic            line_end_c;
  logic            last_line_c;
  logic            frame_start_c;
  logic [VW-1:0]   lines_m1_c;
  logic [2:0]      bar_c;
  logic [15:0]     color_c;
  logic            vsync_c;
  logic            href_c;
  logic            req_c;
  logic            done_c;
  logic [7:0]      data_c;

  // Colour bar table, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  assign line_end_c = (h_cnt == HW'(LINE_LEN - 1));

  // Number of lines (minus one) spent in the current state.
  always_comb begin
    lines_m1_c = '0;
    case (state)
      VSYNC:   lines_m1_c = VW'(VS_LINES - 1);
      VBACK:   lines_m1_c = VW'(V_BACK - 1);
      ACTIVE:  lines_m1_c = VW'(V_PIXEL - 1);
      VFRONT:  lines_m1_c = VW'(V_FRONT - 1);
      default: lines_m1_c = '0;
    endcase
  end

  assign last_line_c   = (v_cnt == lines_m1_c);
  assign frame_start_c = (state_next == VSYNC) && (state != VSYNC);

  // Pixel x = h_cnt/2; bar index = x*8/H_PIXEL.
  assign bar_c = 3'((32'(h_cnt[HW-1:1]) * 32'd8) / H_PIXEL);

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Line/position counters and per-frame source select.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      pattern <= 1'b0;
    end else begin
      if (state == IDLE || line_end_c) begin
        h_cnt <= '0;
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (state_next != state) begin
        v_cnt <= '0;
      end else if (line_end_c) begin
        v_cnt <= v_cnt + VW'(1);
      end
      if (frame_start_c) begin
        pattern <= use_pattern;
      end
    end
  end

  // Next-state logic: every non-idle state lasts a whole number of lines.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = VSYNC;
      VSYNC:   if (line_end_c && last_line_c) state_next = VBACK;
      VBACK:   if (line_end_c && last_line_c) state_next = ACTIVE;
      ACTIVE:  if (line_end_c && last_line_c) state_next = VFRONT;
      VFRONT:  if (line_end_c && last_line_c) state_next = enable ? VSYNC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; values land on the pins one clock later.
  always_comb begin
    vsync_c = 1'b0;
    href_c  = 1'b0;
    req_c   = 1'b0;
    done_c  = 1'b0;
    data_c  = '0;
    color_c = bar_color(bar_c);

    vsync_c = (state == VSYNC);
    href_c  = (state == ACTIVE) && (32'(h_cnt) < ACT_CLKS);
    done_c  = (state == VFRONT) && last_line_c && line_end_c;

    // Request lands two clocks ahead of each high byte. Inside a line that
    // is every even slot but the last; the first pixel of a line is requested
    // from the tail of the preceding blank.
    if (!pattern) begin
      if (state == ACTIVE && !h_cnt[0] && (32'(h_cnt) + 32'd2 < ACT_CLKS)) begin
        req_c = 1'b1;
      end
      if (h_cnt == HW'(LINE_LEN - 2) &&
          ((state == VBACK && last_line_c) || (state == ACTIVE && !last_line_c))) begin
        req_c = 1'b1;
      end
    end

    if (href_c) begin
      if (pattern) begin
        data_c = h_cnt[0] ? color_c[7:0] : color_c[15:8];
      end else begin
        data_c = h_cnt[0] ? pix_hold[7:0] : pix_data[15:8];
      end
    end
  end

  // Output registers; pix_hold keeps the low byte for the following clock.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= '0;
      pix_req    <= 1'b0;
      frame_done <= 1'b0;
      pix_hold   <= '0;
    end else begin
      cam_vsync  <= vsync_c;
      cam_href   <= href_c;
      cam_data   <= data_c;
      pix_req    <= req_c;
      frame_done <= done_c;
      if (href_c && !h_cnt[0]) begin
        pix_hold <= pix_data;
      end
    end
  end

endmodule
